// File: rtl/req_sync_bridge.sv
// req_sync_bridge: synchronises a 2-phase request, buffers bundled data in a 2-entry FIFO, acks and presents valid/ready
module req_sync_bridge #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inR,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  inA,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  o_ready,
   output logic                  o_full
);
   logic [SYNC_STAGES-1:0] syncR;
   logic [DATA_WIDTH-1:0]  mem [2];
   logic                   wrPtr, rdPtr;
   logic [1:0]             count;
   logic                   reqS, accept, pop;
   assign reqS    = syncR[SYNC_STAGES-1];
   assign o_valid = count != 2'd0;
   assign o_full  = count == 2'd2;
   assign o_data  = mem[rdPtr];
   // full is the registered value, so a pop never makes room for a same-cycle accept
   assign accept  = (reqS != inA) & ~o_full;
   assign pop     = o_valid & o_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         syncR  <= '0;
         inA    <= 1'b0;
         wrPtr  <= 1'b0;
         rdPtr  <= 1'b0;
         count  <= 2'd0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         syncR <= {syncR[SYNC_STAGES-2:0], inR};
         if (accept) begin
            mem[wrPtr] <= i_data;
            inA        <= reqS;
            wrPtr      <= ~wrPtr;
         end
         if (pop) rdPtr <= ~rdPtr;
         count <= count + {1'b0, accept} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_req_sync_bridge.sv
// tb_req_sync_bridge: directed tokens with a scoreboard queue checked by an independent output monitor
module tb_req_sync_bridge;
   logic        clk = 1'b0;
   logic        rst, inR, o_ready;
   logic [31:0] i_data;
   logic        inA, o_valid, o_full;
   logic [31:0] o_data;
   logic        inA3, oValid3, oFull3;
   logic [31:0] oData3;
   logic [31:0] expQ [$];
   int          vectors = 0;
   int          errs = 0;

   req_sync_bridge #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .inR(inR), .i_data(i_data), .inA(inA),
      .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready), .o_full(o_full));

   req_sync_bridge #(.DATA_WIDTH(32), .SYNC_STAGES(3)) dut3 (
      .clk(clk), .rst(rst), .inR(inR), .i_data(i_data), .inA(inA3),
      .o_valid(oValid3), .o_data(oData3), .o_ready(o_ready), .o_full(oFull3));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendTok(input logic [31:0] d);
      i_data = d;
      inR = ~inR;
      expQ.push_back(d);
   endtask

   task automatic waitAck();
      int n = 0;
      while (inA !== inR && n < 20) begin
         tick();
         n++;
      end
      chk("ack", {31'd0, inA}, {31'd0, inR});
   endtask

   // the pop happens at the next rising edge, so compare the head now
   always @(negedge clk) begin
      if (!rst && o_valid && o_ready) begin
         if (expQ.size() == 0) begin
            vectors++;
            errs++;
            $display("FAIL unexpected_pop: got %h expected none", o_data);
         end else begin
            chk("pop_data", o_data, expQ.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; inR = 1'b0; o_ready = 1'b0; i_data = '0;
      tick(2);
      rst = 1'b0;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_full", {31'd0, o_full}, 32'd0);
      chk("rst_inA", {31'd0, inA}, 32'd0);
      chk("rst_data", o_data, 32'd0);
      chk("rst_valid3", {31'd0, oValid3}, 32'd0);

      // single token latency, 2 and 3 stage synchronisers
      sendTok(32'hA5A5_0001);
      tick();
      chk("lat_e0_valid", {31'd0, o_valid}, 32'd0);
      tick();
      chk("lat_e1_valid", {31'd0, o_valid}, 32'd0);
      chk("lat_e1_inA", {31'd0, inA}, 32'd0);
      tick();
      chk("lat_e2_valid", {31'd0, o_valid}, 32'd1);
      chk("lat_e2_inA", {31'd0, inA}, 32'd1);
      chk("lat_e2_data", o_data, 32'hA5A5_0001);
      chk("lat3_e2_valid", {31'd0, oValid3}, 32'd0);
      tick();
      chk("lat3_e3_valid", {31'd0, oValid3}, 32'd1);
      chk("lat3_e3_data", oData3, 32'hA5A5_0001);
      o_ready = 1'b1;
      tick();
      chk("drain1_valid", {31'd0, o_valid}, 32'd0);
      o_ready = 1'b0;

      // fill and backpressure
      sendTok(32'h11); waitAck();
      sendTok(32'h22); waitAck();
      chk("fill_full", {31'd0, o_full}, 32'd1);
      sendTok(32'h33);
      tick(4);
      chk("bp_noack", {31'd0, inA}, {31'd0, ~inR});
      chk("bp_full", {31'd0, o_full}, 32'd1);
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      chk("bp_pop_noack", {31'd0, inA}, {31'd0, ~inR});
      tick();
      chk("bp_ack_after_pop", {31'd0, inA}, {31'd0, inR});
      chk("bp_full_again", {31'd0, o_full}, 32'd1);
      o_ready = 1'b1;
      tick(3);
      chk("bp_drained", {31'd0, o_valid}, 32'd0);
      chk("bp_q_empty", expQ.size(), 32'd0);
      o_ready = 1'b0;

      // accept and pop in the same cycle with one token buffered
      sendTok(32'h44); waitAck();
      sendTok(32'h55);
      tick(2);
      o_ready = 1'b1;
      tick();
      chk("pp_ack", {31'd0, inA}, {31'd0, inR});
      chk("pp_valid", {31'd0, o_valid}, 32'd1);
      chk("pp_full", {31'd0, o_full}, 32'd0);
      chk("pp_data", o_data, 32'h55);
      tick();
      chk("pp_drained", {31'd0, o_valid}, 32'd0);
      chk("pp_q_empty", expQ.size(), 32'd0);

      // pointer wrap
      for (int i = 1; i <= 6; i++) begin
         sendTok(i);
         waitAck();
      end
      tick(2);
      chk("wrap_q_empty", expQ.size(), 32'd0);
      chk("wrap_valid", {31'd0, o_valid}, 32'd0);
      o_ready = 1'b0;

      // reset mid-operation
      sendTok(32'h61); waitAck();
      sendTok(32'h62); waitAck();
      chk("mr_full", {31'd0, o_full}, 32'd1);
      rst = 1'b1; inR = 1'b0;
      tick();
      rst = 1'b0;
      expQ.delete();
      chk("mr_valid", {31'd0, o_valid}, 32'd0);
      chk("mr_inA", {31'd0, inA}, 32'd0);
      chk("mr_full0", {31'd0, o_full}, 32'd0);
      tick(3);
      chk("mr_quiet", {31'd0, o_valid}, 32'd0);
      sendTok(32'h77);
      o_ready = 1'b1;
      waitAck();
      tick(2);
      chk("mr_q_empty", expQ.size(), 32'd0);
      chk("mr_valid_end", {31'd0, o_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
